branch_resolver: RTL and testbench

Sequential branch-resolution unit between decode and the `compare` unit. Accepts one branch request at a time over a valid/ready handshake, drives operands and a compare opcode into `compare`, samples `flag_out` back, and emits a single-cycle resolve pulse with the next-PC and a flush request. It is the initiator/consumer end of the `compare` interface.

---
 rtl/branch_resolver.sv | 146 ++++++++++++++
 tb/tb_branch_resolver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Sequential branch resolver: latches one branch, drives the compare unit for a cycle, then emits a resolve pulse.
// Optional statistics counters are enabled with `define BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [31:0]       req_pc,
    input  logic [15:0]       req_offset,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic              kill,
    output logic [31:0]       cmp_a,
    output logic [31:0]       cmp_b,
    output logic [4:0]        cmp_op,
    input  logic              cmp_flag,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic [31:0]       resolve_pc,
    output logic              flush,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_taken
);
    localparam logic [1:0] IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2;
    localparam logic [1:0] K_BEQ = 2'd0, K_BNE = 2'd1, K_J = 2'd2;
    localparam logic [4:0] OP_EQ = 5'd17, OP_NE = 5'd18, OP_NONE = 5'd0;

    logic [1:0]  state_q;
    logic [1:0]  kind_q;
    logic [31:0] pc_q;
    logic [15:0] off_q;
    logic [31:0] cmp_a_q, cmp_b_q;
    logic [4:0]  cmp_op_q;
    logic        rv_q, rt_q;
    logic [31:0] rpc_q;

    logic        taken_d;
    logic [31:0] seq_pc, target;
    logic [4:0]  op_d;

    always_comb begin
        case (kind_q)
            K_BEQ, K_BNE: taken_d = cmp_flag;
            K_J:          taken_d = 1'b1;
            default:      taken_d = 1'b0;
        endcase
    end

    always_comb begin
        case (req_kind)
            K_BEQ:   op_d = OP_EQ;
            K_BNE:   op_d = OP_NE;
            default: op_d = OP_NONE;
        endcase
    end

    // Both PC sums wrap modulo 2^32 by construction.
    assign seq_pc = pc_q + 32'd4;
    assign target = seq_pc + {{14{off_q[15]}}, off_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= 2'd0;
            pc_q     <= 32'd0;
            off_q    <= 16'd0;
            cmp_a_q  <= 32'd0;
            cmp_b_q  <= 32'd0;
            cmp_op_q <= OP_NONE;
            rv_q     <= 1'b0;
            rt_q     <= 1'b0;
            rpc_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !kill) begin
                        kind_q   <= req_kind;
                        pc_q     <= req_pc;
                        off_q    <= req_offset;
                        cmp_a_q  <= req_a;
                        cmp_b_q  <= req_b;
                        cmp_op_q <= op_d;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    cmp_a_q  <= 32'd0;
                    cmp_b_q  <= 32'd0;
                    cmp_op_q <= OP_NONE;
                    if (kill) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        rv_q    <= 1'b1;
                        rt_q    <= taken_d;
                        rpc_q   <= taken_d ? target : seq_pc;
                    end
                end
                DONE: begin
                    // The branch is already resolved, so kill cannot cut this pulse short.
                    state_q <= IDLE;
                    rv_q    <= 1'b0;
                    rt_q    <= 1'b0;
                    rpc_q   <= 32'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = rst_n && (state_q == IDLE);
    assign cmp_a         = cmp_a_q;
    assign cmp_b         = cmp_b_q;
    assign cmp_op        = cmp_op_q;
    assign resolve_valid = rv_q;
    assign resolve_taken = rt_q;
    assign resolve_pc    = rpc_q;
    assign flush         = rv_q & rt_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [STAT_W-1:0] tot_q, tk_q;

    // Counted on the edge that launches the pulse, so kill-aborted requests never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_q <= '0;
            tk_q  <= '0;
        end else if (state_q == CMP && !kill) begin
            if (tot_q != {STAT_W{1'b1}})
                tot_q <= tot_q + STAT_W'(1);
            if (taken_d && tk_q != {STAT_W{1'b1}})
                tk_q <= tk_q + STAT_W'(1);
        end
    end

    assign stat_total = tot_q;
    assign stat_taken = tk_q;
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a behavioural model of the compare unit.
module tb_branch_resolver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_kind;
    logic [31:0] req_pc;
    logic [15:0] req_offset;
    logic [31:0] req_a, req_b;
    logic        kill;
    logic [31:0] cmp_a, cmp_b;
    logic [4:0]  cmp_op;
    logic        cmp_flag;
    logic        resolve_valid, resolve_taken, flush;
    logic [31:0] resolve_pc;
    logic [1:0]  stat_total, stat_taken;

    int n_chk = 0;
    int n_pass = 0;

    branch_resolver #(.STAT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_pc(req_pc), .req_offset(req_offset), .req_a(req_a), .req_b(req_b),
        .kill(kill), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_flag(cmp_flag),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_pc(resolve_pc), .flush(flush),
        .stat_total(stat_total), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    // Compare-unit model: opcode 17 = equal, 18 = not-equal, others return 0.
    assign cmp_flag = (cmp_op == 5'd17) ? (cmp_a == cmp_b) :
                      (cmp_op == 5'd18) ? (cmp_a != cmp_b) : 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [31:0] pc, input logic [15:0] off,
                         input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_kind = k; req_pc = pc; req_offset = off; req_a = a; req_b = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0;
        req_kind = 2'd0; req_pc = '0; req_offset = '0; req_a = '0; req_b = '0;
        #2;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready); else n_pass++;
        n_chk++; if ({resolve_valid, resolve_taken, flush, resolve_pc, cmp_op, cmp_a, cmp_b} !== '0)
            $display("FAIL rst_outs got nonzero rv=%b pc=%h op=%0d", resolve_valid, resolve_pc, cmp_op); else n_pass++;
        n_chk++; if ({stat_total, stat_taken} !== 4'd0) $display("FAIL rst_stats got %h exp 0", {stat_total, stat_taken}); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_ready_rel got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_resolve();
        logic [1:0]  vk[6]   = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] vpc[6]  = '{32'h1000, 32'h2000, 32'hFFFF_FFF8, 32'h3000, 32'h4000, 32'h10};
        logic [15:0] voff[6] = '{16'h0004, 16'hFFFF, 16'h0001, 16'hFFFE, 16'h8000, 16'h0005};
        logic [31:0] va[6]   = '{32'd5, 32'd7, 32'd0, 32'd1, 32'd1, 32'd9};
        logic [31:0] vb[6]   = '{32'd5, 32'd7, 32'd0, 32'd2, 32'd2, 32'd9};
        logic [4:0]  vop[6]  = '{5'd17, 5'd18, 5'd0, 5'd17, 5'd18, 5'd0};
        logic        vtk[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] vrpc[6] = '{32'h1014, 32'h2004, 32'h0, 32'h3004, 32'hFFFE_4004, 32'h14};
        for (int i = 0; i < 6; i++) begin
            drive(vk[i], vpc[i], voff[i], va[i], vb[i]);
            tick();
            req_valid = 1'b0;
            n_chk++; if (req_ready !== 1'b0) $display("FAIL v%0d cmp_ready got %b exp 0", i, req_ready); else n_pass++;
            n_chk++; if (cmp_op !== vop[i]) $display("FAIL v%0d cmp_op got %0d exp %0d", i, cmp_op, vop[i]); else n_pass++;
            n_chk++; if ({cmp_a, cmp_b} !== {va[i], vb[i]}) $display("FAIL v%0d cmp_ab got %h/%h exp %h/%h", i, cmp_a, cmp_b, va[i], vb[i]); else n_pass++;
            n_chk++; if (resolve_valid !== 1'b0) $display("FAIL v%0d early_rv got %b exp 0", i, resolve_valid); else n_pass++;
            tick();
            n_chk++; if (resolve_valid !== 1'b1) $display("FAIL v%0d rv got %b exp 1", i, resolve_valid); else n_pass++;
            n_chk++; if (resolve_taken !== vtk[i]) $display("FAIL v%0d taken got %b exp %b", i, resolve_taken, vtk[i]); else n_pass++;
            n_chk++; if (resolve_pc !== vrpc[i]) $display("FAIL v%0d rpc got %h exp %h", i, resolve_pc, vrpc[i]); else n_pass++;
            n_chk++; if (flush !== vtk[i]) $display("FAIL v%0d flush got %b exp %b", i, flush, vtk[i]); else n_pass++;
            n_chk++; if ({cmp_op, cmp_a, cmp_b} !== '0) $display("FAIL v%0d cmp_clr got op=%0d a=%h", i, cmp_op, cmp_a); else n_pass++;
            n_chk++; if (req_ready !== 1'b0) $display("FAIL v%0d done_ready got %b exp 0", i, req_ready); else n_pass++;
            tick();
            n_chk++; if ({resolve_valid, flush} !== 2'b00) $display("FAIL v%0d rv_end got %b exp 0", i, resolve_valid); else n_pass++;
            n_chk++; if (req_ready !== 1'b1) $display("FAIL v%0d idle_ready got %b exp 1", i, req_ready); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        drive(2'd2, 32'h100, 16'h0000, 32'd0, 32'd0);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (resolve_valid === 1'b1) pulses++;
            n_chk++; if (req_ready !== (k % 3 == 2)) $display("FAIL b2b k%0d ready got %b exp %b", k, req_ready, (k % 3 == 2)); else n_pass++;
            n_chk++; if (resolve_valid !== (k % 3 == 1)) $display("FAIL b2b k%0d rv got %b exp %b", k, resolve_valid, (k % 3 == 1)); else n_pass++;
            if (k % 3 == 1) begin
                n_chk++; if (resolve_pc !== 32'h104) $display("FAIL b2b k%0d rpc got %h exp 00000104", k, resolve_pc); else n_pass++;
            end
        end
        req_valid = 1'b0;
        tick();
        n_chk++; if (pulses != 3) $display("FAIL b2b pulses got %0d exp 3", pulses); else n_pass++;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL b2b idle got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_kill();
        // kill in IDLE blocks acceptance
        drive(2'd2, 32'h500, 16'h0001, 32'd0, 32'd0);
        kill = 1'b1;
        tick();
        req_valid = 1'b0; kill = 1'b0;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL kill_idle ready got %b exp 1", req_ready); else n_pass++;
        n_chk++; if (cmp_op !== 5'd0 || cmp_a !== 32'd0) $display("FAIL kill_idle cmp got op=%0d exp 0", cmp_op); else n_pass++;
        tick();
        n_chk++; if (resolve_valid !== 1'b0) $display("FAIL kill_idle rv got %b exp 0", resolve_valid); else n_pass++;
        // kill in CMP aborts without a pulse
        drive(2'd0, 32'h600, 16'h0002, 32'd3, 32'd3);
        tick();
        req_valid = 1'b0; kill = 1'b1;
        tick();
        kill = 1'b0;
        n_chk++; if (resolve_valid !== 1'b0) $display("FAIL kill_cmp rv got %b exp 0", resolve_valid); else n_pass++;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL kill_cmp ready got %b exp 1", req_ready); else n_pass++;
        n_chk++; if (cmp_op !== 5'd0) $display("FAIL kill_cmp op got %0d exp 0", cmp_op); else n_pass++;
        tick();
        n_chk++; if (resolve_valid !== 1'b0) $display("FAIL kill_cmp rv2 got %b exp 0", resolve_valid); else n_pass++;
        // kill in DONE does not cut the pulse
        drive(2'd2, 32'h700, 16'h0001, 32'd0, 32'd0);
        tick();
        req_valid = 1'b0;
        tick();
        kill = 1'b1;
        #2;
        n_chk++; if (resolve_valid !== 1'b1 || resolve_pc !== 32'h708) $display("FAIL kill_done rv=%b rpc got %h exp 1/00000708", resolve_valid, resolve_pc); else n_pass++;
        tick();
        kill = 1'b0;
        n_chk++; if (resolve_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL kill_done end rv=%b ready=%b exp 0/1", resolve_valid, req_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_cmp();
        drive(2'd0, 32'h800, 16'h0004, 32'd1, 32'd1);
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL midrst ready got %b exp 0", req_ready); else n_pass++;
        n_chk++; if ({cmp_op, cmp_a, cmp_b, resolve_valid, resolve_pc, flush} !== '0) $display("FAIL midrst outs got op=%0d a=%h rv=%b", cmp_op, cmp_a, resolve_valid); else n_pass++;
        n_chk++; if ({stat_total, stat_taken} !== 4'd0) $display("FAIL midrst stats got %h exp 0", {stat_total, stat_taken}); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++; if (resolve_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL midrst after rv=%b ready=%b exp 0/1", resolve_valid, req_ready); else n_pass++;
    endtask

    task automatic test_stats();
        int tot = 0, tk = 0;
        for (int i = 0; i < 6; i++) begin
            // first branch is a not-taken BNE, then five unconditional jumps
            if (i == 0) drive(2'd1, 32'h900, 16'h0001, 32'd7, 32'd7);
            else        drive(2'd2, 32'h900, 16'h0001, 32'd0, 32'd0);
            tick();
            req_valid = 1'b0;
            tick(); tick();
            tot = (tot == 3) ? 3 : tot + 1;
            if (i != 0) tk = (tk == 3) ? 3 : tk + 1;
`ifndef BRANCH_RESOLVER_STATS_EN
            tot = 0; tk = 0;
`endif
            n_chk++; if (stat_total !== 2'(tot)) $display("FAIL stat_total i%0d got %0d exp %0d", i, stat_total, tot); else n_pass++;
            n_chk++; if (stat_taken !== 2'(tk)) $display("FAIL stat_taken i%0d got %0d exp %0d", i, stat_taken, tk); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_resolve();
        test_back_to_back();
        test_kill();
        test_reset_mid_cmp();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
